// File: rtl/sprite_pkg.sv
// ============================================================================
// Module  : sprite_pkg
// Purpose : Shared sprite RAM constants, layout types and anim-to-layout map.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

  localparam int NUM_ANIM = 10;

  localparam logic [3:0] ANIM_IDLE       = 4'd0;
  localparam logic [3:0] ANIM_WALKING    = 4'd1;
  localparam logic [3:0] ANIM_HIT        = 4'd2;
  localparam logic [3:0] ANIM_JUMP       = 4'd3;
  localparam logic [3:0] ANIM_LOW_PUNCH  = 4'd4;
  localparam logic [3:0] ANIM_MID_PUNCH  = 4'd5;
  localparam logic [3:0] ANIM_HIGH_KICK  = 4'd6;
  localparam logic [3:0] ANIM_CROUCH     = 4'd7;
  localparam logic [3:0] ANIM_BLOCK_LOW  = 4'd8;
  localparam logic [3:0] ANIM_BLOCK_HIGH = 4'd9;

  localparam int ROWS_DEF     = 105;
  localparam int W_NORMAL_DEF = 200;
  localparam int W_ATTACK_DEF = 256;
  localparam int W_SINGLE_DEF = 50;

  localparam int PIX_NORMAL = W_NORMAL_DEF * ROWS_DEF;  // 21000
  localparam int PIX_SINGLE = W_SINGLE_DEF * ROWS_DEF;  // 5250
  localparam int PIX_ATTACK = W_ATTACK_DEF * ROWS_DEF;  // 26880

  localparam int ADDR_W = 15;

  typedef enum logic [1:0] {
    TYPE_NORMAL = 2'd0,
    TYPE_SINGLE = 2'd1,
    TYPE_ATTACK = 2'd2
  } layout_e;

  function automatic layout_e anim_layout(input logic [3:0] anim);
    if (anim <= ANIM_JUMP)           return TYPE_NORMAL;
    else if (anim <= ANIM_HIGH_KICK) return TYPE_ATTACK;
    else                             return TYPE_SINGLE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_anim_decode.sv
// ============================================================================
// Module  : sprite_anim_decode
// Purpose : Animation id -> last pixel address and one-hot RAM select.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_anim_decode
  import sprite_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int W_NORMAL = W_NORMAL_DEF,
  parameter int W_ATTACK = W_ATTACK_DEF,
  parameter int W_SINGLE = W_SINGLE_DEF
) (
  input  logic [3:0]          anim,
  output logic [ADDR_W-1:0]   last_addr,
  output logic [NUM_ANIM-1:0] onehot
);

  localparam logic [ADDR_W-1:0] LAST_NORMAL = ADDR_W'(W_NORMAL * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ATTACK = ADDR_W'(W_ATTACK * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_SINGLE = ADDR_W'(W_SINGLE * ROWS - 1);

  always_comb begin
    last_addr = LAST_NORMAL;
    case (anim_layout(anim))
      TYPE_ATTACK: last_addr = LAST_ATTACK;
      TYPE_SINGLE: last_addr = LAST_SINGLE;
      default:     last_addr = LAST_NORMAL;
    endcase
  end

  // Ids above the last animation shift the bit out, giving an all-zero select.
  assign onehot = {{(NUM_ANIM-1){1'b0}}, 1'b1} << anim;

endmodule

`default_nettype wire

// File: rtl/sprite_ram_loader.sv
// ============================================================================
// Module  : sprite_ram_loader
// Purpose : Byte-stream writer for the ten fighter sprite RAMs (2 pixels/byte).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_ram_loader
  import sprite_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int W_NORMAL = W_NORMAL_DEF,
  parameter int W_ATTACK = W_ATTACK_DEF,
  parameter int W_SINGLE = W_SINGLE_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic [NUM_ANIM-1:0] wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [3:0]          wr_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WR_LO = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  localparam logic [3:0] ANIM_MAX = 4'(NUM_ANIM - 1);

  logic [1:0]          state_q, state_d;
  logic [3:0]          anim_q, anim_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          csum_q, csum_d;
  logic [3:0]          lo_nib_q, lo_nib_d;
  logic [NUM_ANIM-1:0] wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [3:0]          wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   w_last_addr;
  logic [NUM_ANIM-1:0] w_onehot;
  logic                w_accept;
  logic                w_hdr_ok;
  logic                w_last_pair;

  sprite_anim_decode #(
    .ROWS     (ROWS),
    .W_NORMAL (W_NORMAL),
    .W_ATTACK (W_ATTACK),
    .W_SINGLE (W_SINGLE)
  ) u_decode (
    .anim      (anim_q),
    .last_addr (w_last_addr),
    .onehot    (w_onehot)
  );

  assign w_accept    = in_valid && in_ready;
  assign w_hdr_ok    = (in_data[3:0] == 4'd0) && (in_data[7:4] <= ANIM_MAX);
  assign w_last_pair = (addr_q + ADDR_W'(1)) == w_last_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (w_accept && w_hdr_ok) state_d = ST_LOAD;
      ST_LOAD:  if (w_accept) state_d = ST_WR_LO;
      ST_WR_LO: state_d = w_last_pair ? ST_CHECK : ST_LOAD;
      ST_CHECK: if (w_accept) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q != ST_WR_LO);
  end

  always_comb begin
    anim_d    = anim_q;
    addr_d    = addr_q;
    csum_d    = csum_q;
    lo_nib_d  = lo_nib_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        wr_en_d = '0;
        if (w_accept) begin
          if (w_hdr_ok) begin
            anim_d = in_data[7:4];
            addr_d = '0;
            csum_d = '0;
            err_d  = 1'b0;
            busy_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          wr_en_d   = w_onehot;
          wr_addr_d = addr_q;
          wr_data_d = in_data[7:4];
          lo_nib_d  = in_data[3:0];
          csum_d    = csum_q ^ in_data;
        end else begin
          wr_en_d = '0;
        end
      end
      ST_WR_LO: begin
        wr_addr_d = addr_q + ADDR_W'(1);
        wr_data_d = lo_nib_q;
        // Hold the counter on the final pair so it never passes the last pixel.
        if (!w_last_pair) addr_d = addr_q + ADDR_W'(2);
      end
      ST_CHECK: begin
        wr_en_d = '0;
        if (w_accept) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          err_d  = (in_data != csum_q);
        end
      end
      default: wr_en_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      anim_q    <= '0;
      addr_q    <= '0;
      csum_q    <= '0;
      lo_nib_q  <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      anim_q    <= anim_d;
      addr_q    <= addr_d;
      csum_q    <= csum_d;
      lo_nib_q  <= lo_nib_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_ram_loader.sv
// ============================================================================
// Module  : tb_sprite_ram_loader
// Purpose : Directed self-checking bench for sprite_ram_loader.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sprite_ram_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [9:0]  wr_en;
  logic [14:0] wr_addr;
  logic [3:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;

  sprite_ram_loader dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Pixel byte model: kind 0 = constant pat_val, kind 1 = low byte of index.
  int         pat_kind = 0;
  logic [7:0] pat_val  = 8'h00;
  logic [9:0] exp_en   = 10'h000;

  function automatic logic [7:0] byte_of(input int k);
    logic [7:0] b;
    b = (pat_kind == 1) ? k[7:0] : pat_val;
    return b;
  endfunction

  function automatic logic [7:0] xor_of(input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < n; k++) x = x ^ byte_of(k);
    return x;
  endfunction

  // Write monitor: every write must be the next pixel of the model stream.
  int   wcount, seq_bad, done_cnt, done_cyc, last_addr;
  logic done_err;

  always @(negedge clock) begin
    logic [7:0] b;
    logic [3:0] exp_nib;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err;
    end
    if (wr_en != 10'h000) begin
      b       = byte_of(wcount / 2);
      exp_nib = wcount[0] ? b[3:0] : b[7:4];
      if (wr_en !== exp_en || wr_addr !== wcount[14:0] || wr_data !== exp_nib) seq_bad++;
      last_addr = int'(wr_addr);
      wcount++;
    end
  end

  int timeouts = 0;
  int ready_low = 0;
  int last_acc_cyc = 0;
  int pix_acc_cyc = 0;

  task automatic clear_mon(input logic [9:0] en);
    exp_en = en; wcount = 0; seq_bad = 0; done_cnt = 0; done_cyc = 0;
    last_addr = -1; done_err = 1'b0; ready_low = 0; timeouts = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard;
    guard = 0;
    if (stall && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 50) begin
      ready_low++;
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) timeouts++;
    last_acc_cyc = cyc;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input int n, input logic [7:0] trl, input bit stall);
    send_byte(hdr, 1'b0);
    for (int k = 0; k < n; k++) send_byte(byte_of(k), stall);
    pix_acc_cyc = last_acc_cyc;
    send_byte(trl, stall);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    n_checks++; if (wr_en   !== 10'h000) begin n_fail++; $display("FAIL reset_wr_en got %h want 000", wr_en); end
    n_checks++; if (wr_addr !== 15'd0)   begin n_fail++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
    n_checks++; if (wr_data !== 4'h0)    begin n_fail++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    n_checks++; if (busy    !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done    !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (err     !== 1'b0)    begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    @(negedge clock) reset_n = 1'b1;
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_crouch;
    clear_mon(10'h080);
    pat_kind = 0; pat_val = 8'h5A;
    send_frame(8'h70, 2625, 8'h5A, 1'b0);
    repeat (3) @(negedge clock); #1;
    n_checks++; if (wcount    !== 5250) begin n_fail++; $display("FAIL crouch_writes got %0d want 5250", wcount); end
    n_checks++; if (seq_bad   !== 0)    begin n_fail++; $display("FAIL crouch_sequence got %0d bad want 0", seq_bad); end
    n_checks++; if (last_addr !== 5249) begin n_fail++; $display("FAIL crouch_last_addr got %0d want 5249", last_addr); end
    n_checks++; if (done_cnt  !== 1)    begin n_fail++; $display("FAIL crouch_done_count got %0d want 1", done_cnt); end
    n_checks++; if (done_err  !== 1'b0) begin n_fail++; $display("FAIL crouch_err_at_done got %b want 0", done_err); end
    n_checks++; if (busy      !== 1'b0) begin n_fail++; $display("FAIL crouch_busy_after got %b want 0", busy); end
    n_checks++; if (timeouts  !== 0)    begin n_fail++; $display("FAIL crouch_timeout got %0d want 0", timeouts); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] trl;
    clear_mon(10'h010);
    pat_kind = 1;
    trl = xor_of(13440);
    send_frame(8'h40, 13440, trl, 1'b0);
    repeat (2) @(negedge clock); #1;
    n_checks++; if (wcount    !== 26880) begin n_fail++; $display("FAIL attack_writes got %0d want 26880", wcount); end
    n_checks++; if (seq_bad   !== 0)     begin n_fail++; $display("FAIL attack_sequence got %0d bad want 0", seq_bad); end
    n_checks++; if (last_addr !== 26879) begin n_fail++; $display("FAIL attack_last_addr got %0d want 26879", last_addr); end
    n_checks++; if (ready_low !== 13440) begin n_fail++; $display("FAIL attack_ready_low_cycles got %0d want 13440", ready_low); end
    n_checks++; if (done_cyc - pix_acc_cyc !== 3) begin n_fail++; $display("FAIL attack_done_latency got %0d want 3", done_cyc - pix_acc_cyc); end
    n_checks++; if (done_cnt  !== 1)     begin n_fail++; $display("FAIL attack_done_count got %0d want 1", done_cnt); end
    n_checks++; if (done_err  !== 1'b0)  begin n_fail++; $display("FAIL attack_err_at_done got %b want 0", done_err); end
  endtask

  task automatic test_bad_header;
    clear_mon(10'h000);
    send_byte(8'hA0, 1'b0);
    n_checks++; if (err      !== 1'b1) begin n_fail++; $display("FAIL badhdr_A0_err got %b want 1", err); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL badhdr_A0_ready got %b want 1", in_ready); end
    n_checks++; if (busy     !== 1'b0) begin n_fail++; $display("FAIL badhdr_A0_busy got %b want 0", busy); end
    send_byte(8'h31, 1'b0);
    n_checks++; if (err      !== 1'b1) begin n_fail++; $display("FAIL badhdr_31_err got %b want 1", err); end
    n_checks++; if (busy     !== 1'b0) begin n_fail++; $display("FAIL badhdr_31_busy got %b want 0", busy); end
    n_checks++; if (wcount   !== 0)    begin n_fail++; $display("FAIL badhdr_writes got %0d want 0", wcount); end
  endtask

  task automatic test_checksum_mismatch;
    clear_mon(10'h001);
    pat_kind = 0; pat_val = 8'h00;
    send_byte(8'h00, 1'b0);
    n_checks++; if (err  !== 1'b0) begin n_fail++; $display("FAIL cksum_hdr_err_clear got %b want 0", err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cksum_hdr_busy got %b want 1", busy); end
    for (int k = 0; k < 10500; k++) send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (2) @(negedge clock); #1;
    n_checks++; if (done_cnt  !== 1)     begin n_fail++; $display("FAIL cksum_done_count got %0d want 1", done_cnt); end
    n_checks++; if (done_err  !== 1'b1)  begin n_fail++; $display("FAIL cksum_err_with_done got %b want 1", done_err); end
    n_checks++; if (err       !== 1'b1)  begin n_fail++; $display("FAIL cksum_err_sticky got %b want 1", err); end
    n_checks++; if (wcount    !== 21000) begin n_fail++; $display("FAIL cksum_writes got %0d want 21000", wcount); end
    n_checks++; if (last_addr !== 20999) begin n_fail++; $display("FAIL cksum_last_addr got %0d want 20999", last_addr); end
    n_checks++; if (seq_bad   !== 0)     begin n_fail++; $display("FAIL cksum_sequence got %0d bad want 0", seq_bad); end
  endtask

  task automatic test_stalls;
    logic [7:0] trl;
    clear_mon(10'h200);
    pat_kind = 1;
    trl = xor_of(2625);
    send_frame(8'h90, 2625, trl, 1'b1);
    repeat (2) @(negedge clock); #1;
    n_checks++; if (wcount    !== 5250) begin n_fail++; $display("FAIL stall_writes got %0d want 5250", wcount); end
    n_checks++; if (seq_bad   !== 0)    begin n_fail++; $display("FAIL stall_sequence got %0d bad want 0", seq_bad); end
    n_checks++; if (last_addr !== 5249) begin n_fail++; $display("FAIL stall_last_addr got %0d want 5249", last_addr); end
    n_checks++; if (done_cnt  !== 1)    begin n_fail++; $display("FAIL stall_done_count got %0d want 1", done_cnt); end
    n_checks++; if (done_err  !== 1'b0) begin n_fail++; $display("FAIL stall_err_at_done got %b want 0", done_err); end
    n_checks++; if (timeouts  !== 0)    begin n_fail++; $display("FAIL stall_timeout got %0d want 0", timeouts); end
  endtask

  task automatic test_reset_mid;
    clear_mon(10'h002);
    pat_kind = 1;
    send_byte(8'h10, 1'b0);
    for (int k = 0; k < 100; k++) send_byte(byte_of(k), 1'b0);
    n_checks++; if (wr_en !== 10'h002) begin n_fail++; $display("FAIL midrst_pre_wr_en got %h want 002", wr_en); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (wr_en    !== 10'h000) begin n_fail++; $display("FAIL midrst_wr_en got %h want 000", wr_en); end
    n_checks++; if (wr_addr  !== 15'd0)   begin n_fail++; $display("FAIL midrst_wr_addr got %0d want 0", wr_addr); end
    n_checks++; if (wr_data  !== 4'h0)    begin n_fail++; $display("FAIL midrst_wr_data got %h want 0", wr_data); end
    n_checks++; if (busy     !== 1'b0)    begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    @(negedge clock) reset_n = 1'b1;
    @(negedge clock); #1;
    clear_mon(10'h004);
    send_byte(8'h20, 1'b0);
    for (int k = 0; k < 20; k++) send_byte(byte_of(k), 1'b0);
    repeat (2) @(negedge clock); #1;
    n_checks++; if (wcount  !== 40)   begin n_fail++; $display("FAIL midrst_reload_writes got %0d want 40", wcount); end
    n_checks++; if (seq_bad !== 0)    begin n_fail++; $display("FAIL midrst_reload_sequence got %0d bad want 0", seq_bad); end
    n_checks++; if (busy    !== 1'b1) begin n_fail++; $display("FAIL midrst_reload_busy got %b want 1", busy); end
  endtask

  initial begin
    clear_mon(10'h000);
    test_reset();
    test_crouch();
    test_back_to_back();
    test_bad_header();
    test_checksum_mismatch();
    test_stalls();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
